// File: rtl/tick_gen_multi.sv
// ----------------------------------------------------------------------------
// tick_gen_multi
//   Multi-channel tick generator. Each channel divides clk by a
//   runtime-programmable integer. It produces two outputs:
//     - a one-cycle enable strobe (tick_o)
//     - a 50%-duty square wave (sq_o) that toggles on every tick.
//   Downstream logic stays on clk and qualifies its updates with tick_o.
//
// Ports
//   clk     in   1             system clock, all state on posedge
//   rst     in   1             asynchronous, active-high reset
//   en_i    in   NUM_CH        per-channel run enable (0 = pause, phase held)
//   sync_i  in   NUM_CH        per-channel restart (reload counter, clear sq)
//   div_i   in   NUM_CH*DIV_W  divisor for channel k at [k*DIV_W +: DIV_W]
//   tick_o  out  NUM_CH        registered one-cycle strobe per channel
//   sq_o    out  NUM_CH        registered square wave per channel
// ----------------------------------------------------------------------------
module tick_gen_multi #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 28
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH-1:0]       sync_i,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  output logic [NUM_CH-1:0]       tick_o,
  output logic [NUM_CH-1:0]       sq_o
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DIV_W-1:0] div_w;
      logic [DIV_W-1:0] reload_w;
      logic [DIV_W-1:0] cnt_q, cnt_d;
      logic             tick_q, tick_d;
      logic             sq_q, sq_d;

      assign div_w = div_i[gi*DIV_W +: DIV_W];

      // Reload value is eff-1 where eff = max(div,1); divisors 0 and 1 both
      // reload to 0, so the subtraction can never wrap.
      assign reload_w = (div_w == '0) ? '0 : (div_w - DIV_W'(1));

      // div_i is only looked at on the sync and terminal-count branches, so a
      // divisor change mid-period cannot disturb the period already running.
      always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        sq_d   = sq_q;
        if (sync_i[gi]) begin
          // Restart wins over everything, including a coincident terminal count.
          cnt_d = reload_w;
          sq_d  = 1'b0;
        end else if (!en_i[gi]) begin
          // Paused: phase and square wave hold.
          cnt_d = cnt_q;
        end else if (cnt_q == '0) begin
          cnt_d  = reload_w;
          tick_d = 1'b1;
          sq_d   = ~sq_q;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q  <= '0;
          tick_q <= 1'b0;
          sq_q   <= 1'b0;
        end else begin
          cnt_q  <= cnt_d;
          tick_q <= tick_d;
          sq_q   <= sq_d;
        end
      end

      assign tick_o[gi] = tick_q;
      assign sq_o[gi]   = sq_q;
    end
  endgenerate

endmodule

// File: tb/tb_tick_gen_multi.sv
// ----------------------------------------------------------------------------
// tb_tick_gen_multi
//   Directed bench for tick_gen_multi (4 channels, 8-bit divisors so the
//   maximum divisor 255 runs in a short simulation).
// ----------------------------------------------------------------------------
module tb_tick_gen_multi;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_CH-1:0]       en_i = '0;
  logic [NUM_CH-1:0]       sync_i = '0;
  logic [NUM_CH*DIV_W-1:0] div_i = '0;
  logic [NUM_CH-1:0]       tick_o;
  logic [NUM_CH-1:0]       sq_o;

  int checks   = 0;
  int failures = 0;

  tick_gen_multi #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .en_i   (en_i),
    .sync_i (sync_i),
    .div_i  (div_i),
    .tick_o (tick_o),
    .sq_o   (sq_o)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_div(input int ch, input logic [DIV_W-1:0] v);
    div_i[ch*DIV_W +: DIV_W] = v;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    en_i   = 4'b0001;
    set_div(0, 8'd4);
    step();
    step();
    checks++;
    if (tick_o !== 4'b0000 || sq_o !== 4'b0000) begin
      failures++;
      $display("FAIL reset_state tick=%b sq=%b exp tick=0000 sq=0000", tick_o, sq_o);
    end
    rst = 1'b0;
    $display("test_reset: outputs tick=%b sq=%b during reset", tick_o, sq_o);
  endtask

  // ch0 div=4: ticks at cycles 1,5,9,13; sq 1,1,1,1,0,0,0,0,...
  task automatic test_div4();
    logic exp_tick, exp_sq;
    for (int c = 1; c <= 16; c++) begin
      step();
      exp_tick = ((c % 4) == 1);
      exp_sq   = (((c - 1) / 4) % 2) == 0;
      checks++;
      if (tick_o[0] !== exp_tick || sq_o[0] !== exp_sq || tick_o[3:1] !== 3'b000) begin
        failures++;
        $display("FAIL div4 c=%0d tick=%b sq0=%b exp tick0=%b sq0=%b others=000",
                 c, tick_o, sq_o[0], exp_tick, exp_sq);
      end
    end
    $display("test_div4: 16 cycles checked on ch0");
  endtask

  // ch1 div=0 then div=1: tick every cycle, sq toggles every cycle.
  task automatic test_div0_div1();
    set_div(1, 8'd0);
    en_i[1]   = 1'b1;
    sync_i[1] = 1'b1;
    step();
    sync_i[1] = 1'b0;
    checks++;
    if (tick_o[1] !== 1'b0 || sq_o[1] !== 1'b0) begin
      failures++;
      $display("FAIL div0_sync tick1=%b sq1=%b exp 0 0", tick_o[1], sq_o[1]);
    end
    for (int c = 1; c <= 8; c++) begin
      if (c == 5) set_div(1, 8'd1);
      step();
      checks++;
      if (tick_o[1] !== 1'b1 || sq_o[1] !== logic'(c % 2)) begin
        failures++;
        $display("FAIL div0_div1 c=%0d tick1=%b sq1=%b exp 1 %0d", c, tick_o[1], sq_o[1], c % 2);
      end
    end
    $display("test_div0_div1: ch1 ticked every cycle for div 0 and 1");
  endtask

  // ch0 div=10, switch to 3 when cnt=6: ticks at 10,20,23,26,29 after sync.
  task automatic test_div_change();
    logic exp_tick;
    set_div(0, 8'd10);
    sync_i[0] = 1'b1;
    step();
    sync_i[0] = 1'b0;
    checks++;
    if (tick_o[0] !== 1'b0 || sq_o[0] !== 1'b0) begin
      failures++;
      $display("FAIL chg_sync tick0=%b sq0=%b exp 0 0", tick_o[0], sq_o[0]);
    end
    for (int k = 1; k <= 29; k++) begin
      step();
      if (k == 13) set_div(0, 8'd3);   // counter now holds 6
      exp_tick = (k == 10) || (k == 20) || (k == 23) || (k == 26) || (k == 29);
      checks++;
      if (tick_o[0] !== exp_tick) begin
        failures++;
        $display("FAIL div_change k=%0d tick0=%b exp %b", k, tick_o[0], exp_tick);
      end
    end
    $display("test_div_change: gap 10 kept, then period 3");
  endtask

  // ch2 div=8, pause 5 cycles two cycles after a tick: ticks at 8 and 21.
  task automatic test_pause();
    logic exp_tick, exp_sq;
    set_div(2, 8'd8);
    en_i[2]   = 1'b1;
    sync_i[2] = 1'b1;
    step();
    sync_i[2] = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (k == 10) en_i[2] = 1'b0;
      if (k == 15) en_i[2] = 1'b1;
      exp_tick = (k == 8) || (k == 21);
      exp_sq   = (k >= 8) && (k < 21);
      checks++;
      if (tick_o[2] !== exp_tick || sq_o[2] !== exp_sq) begin
        failures++;
        $display("FAIL pause k=%0d tick2=%b sq2=%b exp %b %b", k, tick_o[2], sq_o[2], exp_tick, exp_sq);
      end
    end
    $display("test_pause: ch2 next tick 13 cycles after previous");
  endtask

  // ch3 div=6: sync while paused, tick 6 cycles after en; sync on cnt==0 gives no tick.
  task automatic test_sync();
    logic exp_tick, exp_sq;
    set_div(3, 8'd6);
    en_i[3]   = 1'b0;
    sync_i[3] = 1'b1;
    step();
    sync_i[3] = 1'b0;
    step();
    step();
    checks++;
    if (tick_o[3] !== 1'b0 || sq_o[3] !== 1'b0) begin
      failures++;
      $display("FAIL sync_paused tick3=%b sq3=%b exp 0 0", tick_o[3], sq_o[3]);
    end
    en_i[3] = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      step();
      sync_i[3] = (k == 11);           // lands on the edge where cnt==0
      exp_tick  = (k == 6) || (k == 18);
      exp_sq    = (k >= 6) && (k < 12) || (k >= 18);
      checks++;
      if (tick_o[3] !== exp_tick || sq_o[3] !== exp_sq) begin
        failures++;
        $display("FAIL sync k=%0d tick3=%b sq3=%b exp %b %b", k, tick_o[3], sq_o[3], exp_tick, exp_sq);
      end
    end
    $display("test_sync: ch3 restart behaviour checked");
  endtask

  // All channels concurrently (4,7,1,255), then asynchronous reset mid-period.
  task automatic test_concurrent_async_reset();
    logic [NUM_CH-1:0] exp_v;
    set_div(0, 8'd4);
    set_div(1, 8'd7);
    set_div(2, 8'd1);
    set_div(3, 8'd255);
    en_i   = 4'b1111;
    sync_i = 4'b1111;
    step();
    sync_i = 4'b0000;
    checks++;
    if (tick_o !== 4'b0000 || sq_o !== 4'b0000) begin
      failures++;
      $display("FAIL conc_sync tick=%b sq=%b exp 0000 0000", tick_o, sq_o);
    end
    for (int k = 1; k <= 255; k++) begin
      step();
      exp_v = {(k % 255) == 0, 1'b1, (k % 7) == 0, (k % 4) == 0};
      checks++;
      if (tick_o !== exp_v) begin
        failures++;
        $display("FAIL concurrent k=%0d tick=%b exp %b", k, tick_o, exp_v);
      end
    end
    // Between edges: assert rst and look before the next edge arrives.
    #3 rst = 1'b1;
    #1;
    checks++;
    if (tick_o !== 4'b0000 || sq_o !== 4'b0000) begin
      failures++;
      $display("FAIL async_reset tick=%b sq=%b exp 0000 0000", tick_o, sq_o);
    end
    #1 rst = 1'b0;
    step();
    checks++;
    if (tick_o !== 4'b1111 || sq_o !== 4'b1111) begin
      failures++;
      $display("FAIL post_reset tick=%b sq=%b exp 1111 1111", tick_o, sq_o);
    end
    $display("test_concurrent_async_reset: 255 cycles plus async reset checked");
  endtask

  initial begin
    test_reset();
    test_div4();
    test_div0_div1();
    test_div_change();
    test_pause();
    test_sync();
    test_concurrent_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
